// File: rtl/ts19_pkg.sv
// Shared definitions for the TS19A64 control sequencer: opcodes, FSM states,
// instruction field positions, status flag indices and the datapath control bundle.
package ts19_pkg;

    localparam logic [4:0] OP_ALU_MAX = 5'h17;
    localparam logic [4:0] OP_LDI     = 5'h18;
    localparam logic [4:0] OP_BZ      = 5'h1C;
    localparam logic [4:0] OP_BN      = 5'h1D;
    localparam logic [4:0] OP_JMP     = 5'h1E;
    localparam logic [4:0] OP_HALT    = 5'h1F;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 27;
    localparam int DA_MSB  = 26;
    localparam int DA_LSB  = 22;
    localparam int AA_MSB  = 21;
    localparam int AA_LSB  = 17;
    localparam int BA_MSB  = 16;
    localparam int BA_LSB  = 12;
    localparam int IMM_MSB = 11;
    localparam int IMM_W   = 12;

    localparam int ST_V = 3;
    localparam int ST_C = 2;
    localparam int ST_N = 1;
    localparam int ST_Z = 0;

    typedef struct packed {
        logic [4:0]  ddl;
        logic [4:0]  aal;
        logic [4:0]  bbl;
        logic [4:0]  fsl;
        logic        mb;
        logic [15:0] imm;
    } dp_ctrl_t;

    localparam dp_ctrl_t CTRL_RESET = '{ddl: 5'h00, aal: 5'h00, bbl: 5'h00,
                                        fsl: 5'h00, mb: 1'b0, imm: 16'h0000};

    function automatic logic [15:0] imm_zext(input logic [11:0] imm12);
        return {4'h0, imm12};
    endfunction

endpackage

// File: rtl/ts19_control_sequencer_if.sv
// Instruction-memory req/ack port; the sequencer is the master, memory the slave.
interface ts19_control_sequencer_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ts19_inst_decode.sv
// Combinational instruction decoder: IR word to datapath controls and
// instruction-class flags consumed by the sequencer FSM.
module ts19_inst_decode
    import ts19_pkg::*;
(
    input  logic [31:0] ir,
    output dp_ctrl_t    ctrl,
    output logic        writes_reg,
    output logic        is_branch,
    output logic        is_halt
);

    logic [4:0] op_s;

    assign op_s = ir[OP_MSB:OP_LSB];

    // Field extraction and per-opcode control generation
    always_comb begin
        ctrl.ddl   = ir[DA_MSB:DA_LSB];
        ctrl.aal   = ir[AA_MSB:AA_LSB];
        ctrl.bbl   = ir[BA_MSB:BA_LSB];
        ctrl.fsl   = 5'h00;
        ctrl.mb    = 1'b0;
        ctrl.imm   = imm_zext(ir[IMM_MSB:0]);
        writes_reg = 1'b0;
        is_branch  = 1'b0;
        is_halt    = 1'b0;
        if (op_s <= OP_ALU_MAX) begin
            ctrl.fsl   = op_s;
            writes_reg = 1'b1;
        end else begin
            case (op_s)
                OP_LDI: begin
                    ctrl.fsl   = OP_LDI;
                    ctrl.mb    = 1'b1;
                    writes_reg = 1'b1;
                end
                OP_BZ, OP_BN, OP_JMP: is_branch = 1'b1;
                OP_HALT:              is_halt   = 1'b1;
                default:              writes_reg = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ts19_control_sequencer.sv
// Fetch/decode/execute controller for the TS19A64 datapath: fetches over a
// req/ack port, drives register/function selects and resolves branches from Status.
module ts19_control_sequencer
    import ts19_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
)(
    input  logic                              CLK,
    input  logic                              Reset,
    ts19_control_sequencer_if.master          imem,
    input  logic [3:0]                        Status,
    input  logic                              dp_busy,
    output logic [4:0]                        DDL,
    output logic [4:0]                        AAL,
    output logic [4:0]                        BBL,
    output logic [4:0]                        FSL,
    output logic                              RW,
    output logic                              MB,
    output logic [15:0]                       imm,
    output logic [PC_W-1:0]                   pc,
    output logic                              halted
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    dp_ctrl_t        ctrl_q, ctrl_d;
    dp_ctrl_t        dec_ctrl_s;
    // Cleared by Reset so the first fetch request appears one cycle after release
    logic            run_q, run_d;
    logic            dec_writes_s, dec_branch_s, dec_halt_s;
    logic            fetch_fire_s;
    logic            taken_s;
    logic [4:0]      op_s;
    logic [PC_W-1:0] br_off_s;
    logic [PC_W-1:0] pc_inc_s;
    logic            unused_status_s;

    assign unused_status_s = Status[ST_V] ^ Status[ST_C];
    assign op_s            = ir_q[OP_MSB:OP_LSB];
    assign fetch_fire_s    = (state_q == S_FETCH) & run_q & imem.imem_ack;
    assign pc_inc_s        = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

    ts19_inst_decode u_decode (
        .ir         (ir_d),
        .ctrl       (dec_ctrl_s),
        .writes_reg (dec_writes_s),
        .is_branch  (dec_branch_s),
        .is_halt    (dec_halt_s)
    );

    // Instruction register capture on an accepted fetch
    always_comb begin
        ir_d = ir_q;
        if (fetch_fire_s) begin
            ir_d = imem.imem_rdata;
        end else begin
            ir_d = ir_q;
        end
    end

    // Sign-extend imm12 to the PC width for relative branches
    always_comb begin
        br_off_s = {PC_W{1'b0}};
        for (int i = 0; i < PC_W; i++) begin
            br_off_s[i] = (i < IMM_W) ? ir_q[i] : ir_q[IMM_MSB];
        end
    end

    // Branch condition from the flags present on the EXEC exit cycle
    always_comb begin
        taken_s = 1'b0;
        case (op_s)
            OP_BZ:   taken_s = dec_branch_s & Status[ST_Z];
            OP_BN:   taken_s = dec_branch_s & Status[ST_N];
            OP_JMP:  taken_s = dec_branch_s;
            default: taken_s = 1'b0;
        endcase
    end

    // Next-state, PC and control-field hold logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        run_d   = 1'b1;
        ctrl_d  = ctrl_q;
        if (fetch_fire_s) begin
            ctrl_d = dec_ctrl_s;
        end else begin
            ctrl_d = ctrl_q;
        end
        case (state_q)
            S_FETCH: begin
                if (fetch_fire_s) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (!dp_busy) begin
                    pc_d    = taken_s ? (pc_q + br_off_s) : pc_inc_s;
                    state_d = dec_halt_s ? S_HALT : S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // State, PC, IR and control-field registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0000_0000;
            ctrl_q  <= CTRL_RESET;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
            run_q   <= run_d;
        end
    end

    // RW follows dp_busy within the cycle so the write lands exactly once
    assign RW             = (state_q == S_EXEC) & dec_writes_s & ~dp_busy & ~Reset;
    assign imem.imem_req  = (state_q == S_FETCH) & run_q;
    assign imem.imem_addr = pc_q;
    assign halted         = (state_q == S_HALT);
    assign pc             = pc_q;
    assign DDL            = ctrl_q.ddl;
    assign AAL            = ctrl_q.aal;
    assign BBL            = ctrl_q.bbl;
    assign FSL            = ctrl_q.fsl;
    assign MB             = ctrl_q.mb;
    assign imm            = ctrl_q.imm;

endmodule
